// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl
//   Turns the 4-bit steering command from the line-following direction logic
//   into two H-bridge channels. Each command is decoded into a per-wheel
//   target duty and rotation sense. Duty changes are slew limited. Every
//   wheel reversal passes through zero duty. Ninety-degree pivots are held
//   for a minimum time.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   DIR[3:0]   steering command: [3:2] side, [1:0] severity
//   Direction  1 = forwards, 0 = backwards
//   LPWM/RPWM  left/right motor PWM
//   LFWD/RFWD  left/right rotation sense, 1 = forward
//   Busy       high while pivoting or while a wheel's applied duty differs
//              from its target
module motor_drive_ctrl #(
  parameter int PWM_PERIOD  = 1000,
  parameter int RAMP_DIV    = 5000,
  parameter int RAMP_STEP   = 10,
  parameter int DUTY_CRUISE = 800,
  parameter int DUTY_VEER   = 500,
  parameter int DUTY_HARD   = 200,
  parameter int DUTY_PIVOT  = 600,
  parameter int PIVOT_MIN   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DIR,
  input  logic       Direction,
  output logic       LPWM,
  output logic       RPWM,
  output logic       LFWD,
  output logic       RFWD,
  output logic       Busy
);

  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int CW = (PIVOT_MIN > 0) ? $clog2(PIVOT_MIN + 1) : 1;

  // Duty constants are clamped into 0..PWM_PERIOD.
  function automatic logic [DW-1:0] sat_duty(input int d);
    if (d <= 0)               return '0;
    else if (d >= PWM_PERIOD) return DW'(PWM_PERIOD);
    else                      return DW'(d);
  endfunction

  localparam logic [DW-1:0] D_CRUISE    = sat_duty(DUTY_CRUISE);
  localparam logic [DW-1:0] D_VEER      = sat_duty(DUTY_VEER);
  localparam logic [DW-1:0] D_HARD      = sat_duty(DUTY_HARD);
  localparam logic [DW-1:0] D_PIVOT     = sat_duty(DUTY_PIVOT);
  localparam logic [DW-1:0] D_STEP      = sat_duty(RAMP_STEP);
  localparam logic [PW-1:0] PWM_LAST    = PW'(PWM_PERIOD - 1);
  localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_DIV - 1);
  localparam logic [CW-1:0] PIVOT_LIMIT = CW'(PIVOT_MIN);

  typedef enum logic [1:0] {ST_BRAKE, ST_RUN, ST_PIVOT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           dir_q, dir_d;
  logic                 direction_q, direction_d;
  logic [CW-1:0]        pivot_cnt_q, pivot_cnt_d;
  logic [RW-1:0]        ramp_cnt_q, ramp_cnt_d;
  logic [PW-1:0]        pwm_cnt_q, pwm_cnt_d;
  // Index 0 is the left wheel, index 1 the right wheel.
  logic [1:0][DW-1:0]   tgt_duty_q, tgt_duty_d;
  logic [1:0]           tgt_fwd_q, tgt_fwd_d;
  logic [1:0][DW-1:0]   app_q, app_d;
  logic [1:0]           fwd_q, fwd_d;
  logic [1:0][DW-1:0]   lat_q, lat_d;

  logic                 dec_stop, dec_ninety;
  logic [1:0][DW-1:0]   dec_duty;
  logic [1:0]           dec_fwd;
  logic [1:0][DW-1:0]   eff_duty;
  logic                 ramp_tick, pwm_wrap;

  // Command decode in the forward frame; backwards driving only flips the
  // sense bits, the left/right duty split stays the same.
  always_comb begin
    dec_stop   = 1'b0;
    dec_ninety = 1'b0;
    dec_duty   = {D_CRUISE, D_CRUISE};
    dec_fwd    = 2'b11;
    case (dir_q)
      4'b0000: dec_stop = 1'b0;
      4'b1001: dec_duty[1] = D_VEER;
      4'b1010: dec_duty[1] = D_HARD;
      4'b0101: dec_duty[0] = D_VEER;
      4'b0110: dec_duty[0] = D_HARD;
      4'b1011: begin
        dec_ninety = 1'b1;
        dec_duty   = {D_PIVOT, D_PIVOT};
        dec_fwd    = 2'b01;
      end
      4'b0111: begin
        dec_ninety = 1'b1;
        dec_duty   = {D_PIVOT, D_PIVOT};
        dec_fwd    = 2'b10;
      end
      default: begin
        dec_stop = 1'b1;
        dec_duty = '0;
      end
    endcase
    if (!direction_q) dec_fwd = ~dec_fwd;
  end

  // Mode FSM and target selection. Targets are chosen from the next state so
  // that the decode reaches the target registers one cycle after the input
  // stage. Braking zeroes the duty targets but keeps the target senses.
  always_comb begin
    dir_d       = DIR;
    direction_d = Direction;
    state_d     = state_q;
    pivot_cnt_d = pivot_cnt_q;
    tgt_duty_d  = tgt_duty_q;
    tgt_fwd_d   = tgt_fwd_q;
    case (state_q)
      ST_BRAKE: if (!dec_stop) state_d = ST_RUN;
      ST_RUN: begin
        if (dec_stop) begin
          state_d = ST_BRAKE;
        end else if (dec_ninety) begin
          state_d     = ST_PIVOT;
          pivot_cnt_d = '0;
        end
      end
      ST_PIVOT: begin
        if (dec_stop) begin
          state_d = ST_BRAKE;
        end else if (pivot_cnt_q >= PIVOT_LIMIT) begin
          state_d = ST_RUN;
        end else begin
          pivot_cnt_d = pivot_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_BRAKE;
    endcase
    case (state_d)
      ST_BRAKE: tgt_duty_d = '0;
      ST_RUN: begin
        tgt_duty_d = dec_duty;
        tgt_fwd_d  = dec_fwd;
      end
      ST_PIVOT: begin
        if (state_q != ST_PIVOT) begin
          tgt_duty_d = dec_duty;
          tgt_fwd_d  = dec_fwd;
        end
      end
      default: tgt_duty_d = '0;
    endcase
  end

  // While a wheel's sense disagrees with its target the wheel is steered
  // toward zero, so every reversal crosses zero duty.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eff_duty[i] = (tgt_fwd_q[i] != fwd_q[i]) ? '0 : tgt_duty_q[i];
    end
  end

  // Per-wheel slew and sense flip. The flip is suppressed around braking so
  // a reversal only completes when a driving command asks for it.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      app_d[i] = app_q[i];
      fwd_d[i] = fwd_q[i];
      if (state_d == ST_BRAKE) begin
        app_d[i] = '0;
      end else if ((state_q != ST_BRAKE) && (tgt_fwd_q[i] != fwd_q[i]) &&
                   (app_q[i] == '0)) begin
        fwd_d[i] = tgt_fwd_q[i];
      end else if (ramp_tick) begin
        if (app_q[i] < eff_duty[i]) begin
          app_d[i] = ((eff_duty[i] - app_q[i]) > D_STEP) ? app_q[i] + D_STEP
                                                          : eff_duty[i];
        end else if (app_q[i] > eff_duty[i]) begin
          app_d[i] = ((app_q[i] - eff_duty[i]) > D_STEP) ? app_q[i] - D_STEP
                                                          : eff_duty[i];
        end
      end
    end
  end

  // Free-running slew timer and PWM counter. The compare value is only
  // refreshed at the period wrap so no period is ever cut short.
  always_comb begin
    ramp_tick  = (ramp_cnt_q == RAMP_LAST);
    ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + RW'(1);
    pwm_wrap   = (pwm_cnt_q == PWM_LAST);
    pwm_cnt_d  = pwm_wrap ? '0 : pwm_cnt_q + PW'(1);
    lat_d      = pwm_wrap ? app_q : lat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BRAKE;
      dir_q       <= 4'b1111;
      direction_q <= 1'b1;
      pivot_cnt_q <= '0;
      ramp_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      tgt_duty_q  <= '0;
      tgt_fwd_q   <= 2'b11;
      app_q       <= '0;
      fwd_q       <= 2'b11;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      direction_q <= direction_d;
      pivot_cnt_q <= pivot_cnt_d;
      ramp_cnt_q  <= ramp_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      tgt_duty_q  <= tgt_duty_d;
      tgt_fwd_q   <= tgt_fwd_d;
      app_q       <= app_d;
      fwd_q       <= fwd_d;
      lat_q       <= lat_d;
    end
  end

  assign LPWM = (DW'(pwm_cnt_q) < lat_q[0]);
  assign RPWM = (DW'(pwm_cnt_q) < lat_q[1]);
  assign LFWD = fwd_q[0];
  assign RFWD = fwd_q[1];
  assign Busy = (state_q == ST_PIVOT) || (app_q[0] != tgt_duty_q[0]) ||
                (app_q[1] != tgt_duty_q[1]);

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl
//   Bench for motor_drive_ctrl with small parameters. Each command sent to
//   the scoreboard has its settled wheel behaviour predicted from the
//   steering rules; a monitor waits for the drive to settle, measures the
//   PWM high time over one period plus the sense bits and Busy, and compares.
//   Directed sequences cover ramp timing, pivot hold, braking and reset.
module tb_motor_drive_ctrl;

  localparam int PERIOD = 100;
  localparam int RDIV   = 4;
  localparam int STEP   = 10;
  localparam int CRUISE = 80;
  localparam int VEER   = 50;
  localparam int HARD   = 20;
  localparam int PIVOT  = 60;
  localparam int PMIN   = 200;
  localparam int SETTLE = 450;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dir;
  logic       direction;
  logic       lpwm, rpwm, lfwd, rfwd, busy;

  always #5 clk = ~clk;

  motor_drive_ctrl #(
    .PWM_PERIOD (PERIOD),
    .RAMP_DIV   (RDIV),
    .RAMP_STEP  (STEP),
    .DUTY_CRUISE(CRUISE),
    .DUTY_VEER  (VEER),
    .DUTY_HARD  (HARD),
    .DUTY_PIVOT (PIVOT),
    .PIVOT_MIN  (PMIN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .DIR      (dir),
    .Direction(direction),
    .LPWM     (lpwm),
    .RPWM     (rpwm),
    .LFWD     (lfwd),
    .RFWD     (rfwd),
    .Busy     (busy)
  );

  typedef struct {
    int l_duty;
    int r_duty;
    bit lfwd;
    bit rfwd;
    bit pivot;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_cnt     = 0;
  int   sent_cnt     = 0;
  bit   cur_lfwd     = 1'b1;
  bit   cur_rfwd     = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic fwd);
    dir       = code;
    direction = fwd;
  endtask

  // Settled behaviour of a command: side picks which wheel is inner,
  // severity picks the inner duty; a ninety turn spins the inner wheel
  // backwards at pivot duty. Reverse driving flips both senses. Anything
  // else stops, keeping the senses the wheels already had.
  function automatic exp_t refModel(input logic [3:0] code, input bit fwd,
                                    input bit prev_l, input bit prev_r);
    exp_t       e;
    logic [1:0] side;
    logic [1:0] sev;
    int         inner;
    int         outer;
    bit         inner_fwd;
    side    = code[3:2];
    sev     = code[1:0];
    e.l_duty = 0;
    e.r_duty = 0;
    e.lfwd   = prev_l;
    e.rfwd   = prev_r;
    e.pivot  = 1'b0;
    if (side == 2'b00 && sev == 2'b00) begin
      e.l_duty = CRUISE;
      e.r_duty = CRUISE;
      e.lfwd   = fwd;
      e.rfwd   = fwd;
    end else if ((side == 2'b10 || side == 2'b01) && sev != 2'b00) begin
      inner     = (sev == 2'b01) ? VEER : (sev == 2'b10) ? HARD : PIVOT;
      outer     = (sev == 2'b11) ? PIVOT : CRUISE;
      inner_fwd = (sev != 2'b11);
      e.pivot   = (sev == 2'b11);
      if (side == 2'b10) begin
        e.l_duty = outer;
        e.r_duty = inner;
        e.lfwd   = 1'b1;
        e.rfwd   = inner_fwd;
      end else begin
        e.l_duty = inner;
        e.r_duty = outer;
        e.lfwd   = inner_fwd;
        e.rfwd   = 1'b1;
      end
      if (!fwd) begin
        e.lfwd = ~e.lfwd;
        e.rfwd = ~e.rfwd;
      end
    end
    return e;
  endfunction

  task automatic waitDone(input int target);
    int n = 0;
    while (done_cnt < target && n < SETTLE + 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_timeout", done_cnt >= target, 1);
  endtask

  task automatic scoreTx(input logic [3:0] code, input bit fwd);
    exp_t e;
    @(negedge clk);
    e = refModel(code, fwd, cur_lfwd, cur_rfwd);
    cur_lfwd = e.lfwd;
    cur_rfwd = e.rfwd;
    exp_q.push_back(e);
    sent_cnt++;
    applyStimulus(code, fwd);
    waitDone(sent_cnt);
  endtask

  // Monitor: waits out the worst-case pivot, reversal and PWM reload, then
  // measures one full PWM period against the oldest expectation.
  initial begin : monitor
    exp_t e;
    int   lh, rh, bh;
    forever begin
      wait (exp_q.size() > 0);
      repeat (SETTLE) @(negedge clk);
      lh = 0;
      rh = 0;
      bh = 0;
      repeat (PERIOD) begin
        @(negedge clk);
        lh += int'(lpwm);
        rh += int'(rpwm);
        bh += int'(busy);
      end
      e = exp_q.pop_front();
      checkOutput("left_duty", lh, e.l_duty);
      checkOutput("right_duty", rh, e.r_duty);
      checkOutput("lfwd", lfwd, e.lfwd);
      checkOutput("rfwd", rfwd, e.rfwd);
      if (e.pivot) checkOutput("pivot_busy", bh >= PERIOD - 2, 1);
      else         checkOutput("settled_busy", bh, 0);
      done_cnt++;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] valid_codes [7];
    logic [3:0] code;
    bit         fwd;
    int         n, hi, lh, rh;

    valid_codes = '{4'b0000, 4'b1001, 4'b1010, 4'b0101, 4'b0110, 4'b1011, 4'b0111};
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset_lpwm", lpwm, 0);
    checkOutput("reset_rpwm", rpwm, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_lfwd", lfwd, 1);
    checkOutput("reset_rfwd", rfwd, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Cruise from rest: eight slew steps of ten.
    applyStimulus(4'b0000, 1'b1);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (n == 3) checkOutput("ramp_busy_high", busy, 1);
      if (n > 3 && !busy) break;
    end
    checkOutput("ramp_cycles_in_range", (n >= 28) && (n <= 40), 1);
    scoreTx(4'b0000, 1'b1);

    // Right pivot from cruise; straight command at cycle 50 does not cut it short.
    @(negedge clk);
    applyStimulus(4'b1011, 1'b1);
    n  = 0;
    hi = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 50) applyStimulus(4'b0000, 1'b1);
      if (busy) hi++;
      else if (hi > 0) break;
    end
    checkOutput("pivot_busy_hold", hi >= PMIN, 1);
    checkOutput("pivot_busy_release", n < 1000, 1);
    scoreTx(4'b0000, 1'b1);

    // Reverse and back again.
    scoreTx(4'b0000, 1'b0);
    scoreTx(4'b0000, 1'b1);

    // Hard right, then stop: outputs low within one period plus two.
    scoreTx(4'b1010, 1'b1);
    @(negedge clk);
    applyStimulus(4'b1111, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("stop_busy_low", busy, 0);
    repeat (99) @(negedge clk);
    lh = 0;
    rh = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      lh += int'(lpwm);
      rh += int'(rpwm);
    end
    checkOutput("stop_left_low", lh, 0);
    checkOutput("stop_right_low", rh, 0);

    // Stop in the middle of a left pivot.
    scoreTx(4'b0000, 1'b1);
    @(negedge clk);
    applyStimulus(4'b0111, 1'b1);
    repeat (60) @(negedge clk);
    checkOutput("mid_pivot_busy", busy, 1);
    applyStimulus(4'b1111, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("pivot_stop_brake", busy, 0);
    cur_lfwd = 1'b0;
    cur_rfwd = 1'b1;
    scoreTx(4'b1111, 1'b1);

    // Reset during a reversal ramp.
    scoreTx(4'b0000, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0000, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_lfwd", lfwd, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset_lpwm", lpwm, 0);
    checkOutput("async_reset_rpwm", rpwm, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_lfwd", lfwd, 1);
    checkOutput("async_reset_rfwd", rfwd, 1);
    @(negedge clk);
    rst = 1'b0;
    cur_lfwd = 1'b1;
    cur_rfwd = 1'b1;
    scoreTx(4'b0000, 1'b1);

    // Randomised commands, including undefined codes that must stop.
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 1) == 1) code = valid_codes[$urandom_range(0, 6)];
      else                           code = 4'($urandom_range(0, 15));
      fwd = ($urandom_range(0, 3) != 0);
      scoreTx(code, fwd);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/motor_drive_ctrl.md
# motor_drive_ctrl

Consumes the 4-bit steering command produced by the line-following direction logic and drives the two H-bridge channels. It decodes each command into per-wheel target duty and rotation sense, and slew-limits duty changes. It enforces a zero-duty crossing on every wheel reversal and holds ninety-degree pivots for a minimum time. It sits between the direction controller and the motor driver pins.

## Interface
- PWM_PERIOD, 1000: PWM period in clk cycles; the duty range is 0..PWM_PERIOD.
- RAMP_DIV, 5000: clk cycles between duty slew steps.
- RAMP_STEP, 10: maximum duty change per slew step.
- DUTY_CRUISE, 800: duty for a straight or outer wheel.
- DUTY_VEER, 500: inner-wheel duty for veer commands.
- DUTY_HARD, 200: inner-wheel duty for hard commands.
- DUTY_PIVOT, 600: duty for both wheels during a pivot.
- PIVOT_MIN, 12_500_000: minimum pivot duration in clk cycles.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- DIR  in  4  steering command: [3:2] side (00 proceed, 10 right, 01 left, 11 stop); [1:0] severity (01 veer, 10 hard, 11 ninety).
- Direction  in  1  1 = forwards, 0 = backwards.
- LPWM  out  1  left motor PWM.
- RPWM  out  1  right motor PWM.
- LFWD  out  1  left rotation sense: 1 = forward.
- RFWD  out  1  right rotation sense: 1 = forward.
- Busy  out  1  high in PIVOT, or while either wheel's applied duty differs from its target.

## Operation
- Input stage: DIR and Direction are registered once. All decoding uses the registered copies.
- Forward-frame decode. Each entry gives left duty/sense, then right duty/sense.
  - 00_00: CRUISE/fwd, CRUISE/fwd.
  - 10_01: CRUISE/fwd, VEER/fwd. 10_10: CRUISE/fwd, HARD/fwd.
  - 01_01 and 01_10: mirror images of 10_01 and 10_10.
  - 10_11: PIVOT/fwd, PIVOT/rev. 01_11: PIVOT/rev, PIVOT/fwd.
  - 11_xx and every other code: STOP.
- Direction=0 inverts both sense bits after decode. Left/right duty assignment is unchanged.
- Per-wheel slew: every RAMP_DIV cycles, the applied duty moves toward the target by min(RAMP_STEP, |target−applied|).
- Reversal: if the target sense differs from the current sense bit, the target is treated as 0 until applied duty reaches 0. The sense bit flips on the cycle after applied duty equals 0; the ramp toward the real target then begins.
- FSM states are BRAKE, RUN and PIVOT.
- BRAKE:
  - Applied duties are forced to 0 immediately, with no ramp.
  - Sense bits hold their last values.
  - Exit to RUN when the registered DIR decodes to non-STOP.
- RUN:
  - Targets follow the decode every cycle.
  - A ninety code enters PIVOT and clears the pivot counter.
  - STOP enters BRAKE.
- PIVOT:
  - Targets are latched from the entering code; later non-STOP codes are ignored.
  - The pivot counter increments every cycle.
  - When count ≥ PIVOT_MIN, return to RUN, where the current decode applies.
  - A non-ninety code does not shorten the pivot.
  - STOP at any time enters BRAKE.
- PWM:
  - One shared counter runs 0..PWM_PERIOD−1 and wraps.
  - xPWM = (count < duty_latched).
  - duty_latched loads the applied duty only when count = PWM_PERIOD−1, so there are no mid-period glitches.
  - Duty 0 gives a constant low output; duty ≥ PWM_PERIOD gives a constant high output.
- Widths:
  - Counters are sized by $clog2 of their parameter.
  - Duty is unsigned and saturates at 0 and PWM_PERIOD.
- Reset:
  - State BRAKE.
  - Applied and latched duties are 0.
  - LPWM, RPWM and Busy are 0.
  - LFWD and RFWD are 1.
  - PWM, ramp and pivot counters are 0.
  - Input registers hold 11_11 and Direction=1.

## Timing
- Latency from DIR change to target update is 2 cycles: the input register, then the decode/FSM register.
- Entry to BRAKE forces applied duty to 0 on the same edge the state changes.
- The LPWM/RPWM outputs fall at the next PWM wrap, within PWM_PERIOD+2 cycles of the STOP code.
- The slew timer is free-running. The first step after a target change occurs at its next expiry, which is at most RAMP_DIV cycles later.
- Simultaneous STOP and pivot expiry: STOP wins.
- Simultaneous reversal and STOP: duty goes to 0 at once and the sense bit is not flipped until a non-STOP code requests it.
- Asynchronous rst mid-pivot or mid-ramp returns every register to its reset value immediately.
- Outputs are low from the rst assertion edge.

## Test plan
All scenarios use PWM_PERIOD=100, RAMP_DIV=4, RAMP_STEP=10, CRUISE=80, VEER=50, HARD=20, PIVOT=60, PIVOT_MIN=200.
- Reset, then DIR=00_00 with Direction=1: both duties ramp 0→80 in 8 steps (≤36 cycles) with LFWD=RFWD=1. Afterwards LPWM high for 80 of every 100 cycles, and Busy drops once ramping ends.
- From cruise, DIR=10_10: right duty steps down 80→20 in 6 steps while left stays 80. Then DIR=11_11: both PWMs are low within 102 cycles, with no ramp.
- From cruise, DIR=10_11:
  - Right duty ramps 80→0 and RFWD goes to 0 the cycle after duty reaches 0.
  - Right then ramps to 60; left goes 80→60.
  - Busy stays high for ≥200 cycles even if DIR returns to 00_00 at cycle 50.
- From cruise, toggle Direction to 0: both wheels ramp to 0, both sense bits flip to 0, then ramp back to 80.
- Mid-pivot DIR=11_11: the FSM enters BRAKE within 2 cycles and the duties are 0. Assert rst mid-ramp: all outputs are at reset values the same cycle.
- DIR=00_11 from cruise: decoded as STOP; both PWMs low within 102 cycles.
